// File: rtl/register_unit_mp_pkg.sv
// Shared types and constants for the multi-port register unit.
// Optional write-to-read bypass is selected by REGUNIT_BYPASS_EN.
package regunit_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Low bit of port `port` inside a packed bundle of `width`-bit fields.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/register_unit_mp_if.sv
// Issue/writeback side signals of the register unit; master = pipeline, slave = register unit.
interface register_unit_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rs;
    logic [NRD*XLEN-1:0] Rus;
    logic [NRD-1:0]      RsBusy;
    logic [AW-1:0]       rd;
    logic [XLEN-1:0]     DataWr;
    logic                RuWr;
    logic [AW-1:0]       ResRd;
    logic                ResEn;
    logic                Ready;

    modport master (
        output rs, rd, DataWr, RuWr, ResRd, ResEn,
        input  Rus, RsBusy, Ready
    );

    modport slave (
        input  rs, rd, DataWr, RuWr, ResRd, ResEn,
        output Rus, RsBusy, Ready
    );

endinterface

// File: rtl/register_unit_mp_scoreboard.sv
// Busy-bit scoreboard: reserve sets, writeback clears, reserve wins on the same edge.
// With REGUNIT_BYPASS_EN a same-cycle writeback hides the busy bit it is about to clear.
module regunit_scoreboard
    import regunit_pkg::*;
#(
    parameter  int NREGS = DEF_NREGS,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              en_i,
    input  logic [NRD*AW-1:0] rs_i,
    input  logic [AW-1:0]     rd_i,
    input  logic              wr_i,
    input  logic [AW-1:0]     res_rd_i,
    input  logic              res_en_i,
    output logic [NRD-1:0]    rs_busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (en_i) begin
            if (wr_i && rd_i != '0) busy_d[rd_i] = 1'b0;
            if (res_en_i && res_rd_i != '0) busy_d[res_rd_i] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    always_comb begin
        rs_busy_o = '0;
        for (int i = 0; i < NRD; i++) begin
            rs_busy_o[i] = en_i && busy_q[rs_i[slice_lo(i, AW) +: AW]];
`ifdef REGUNIT_BYPASS_EN
            if (en_i && wr_i && rd_i != '0 && rs_i[slice_lo(i, AW) +: AW] == rd_i &&
                !(res_en_i && res_rd_i == rd_i))
                rs_busy_o[i] = 1'b0;
`endif
        end
    end

endmodule

// File: rtl/register_unit_mp.sv
// Multi-read-port register unit with post-reset hardware clear and busy scoreboard.
// Define REGUNIT_BYPASS_EN to forward same-cycle writeback data to matching read ports.
//
// state | meaning
// INIT  | clearing register[cnt_q] each cycle, operations ignored, outputs read 0
// RUN   | Ready = 1, reads/writes/reserves active until next reset
module register_unit_mp
    import regunit_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = 2
) (
    input logic               CLK,
    input logic               RST_N,
    register_unit_mp_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    state_t          state_q;
    logic [AW-1:0]   cnt_q;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] rdata  [NRD];
    logic            ready;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else if (state_q == INIT) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == AW'(NREGS - 1)) state_q <= RUN;
        end
    end

    assign ready     = (state_q == RUN);
    assign bus.Ready = ready;

    // Storage has no reset: INIT sweeps every entry to zero before Ready.
    always_ff @(posedge CLK) begin
        if (state_q == INIT)
            regs_q[cnt_q] <= '0;
        else if (bus.RuWr && bus.rd != '0)
            regs_q[bus.rd] <= bus.DataWr;
    end

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rdata[i] = '0;
            if (ready && bus.rs[slice_lo(i, AW) +: AW] != '0) begin
                rdata[i] = regs_q[bus.rs[slice_lo(i, AW) +: AW]];
`ifdef REGUNIT_BYPASS_EN
                if (bus.RuWr && bus.rs[slice_lo(i, AW) +: AW] == bus.rd)
                    rdata[i] = bus.DataWr;
`endif
            end
        end
    end

    always_comb begin
        bus.Rus = '0;
        for (int i = 0; i < NRD; i++)
            bus.Rus[slice_lo(i, XLEN) +: XLEN] = rdata[i];
    end

    regunit_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD)
    ) u_scoreboard (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .en_i      (ready),
        .rs_i      (bus.rs),
        .rd_i      (bus.rd),
        .wr_i      (bus.RuWr),
        .res_rd_i  (bus.ResRd),
        .res_en_i  (bus.ResEn),
        .rs_busy_o (bus.RsBusy)
    );

endmodule

// File: tb/tb_register_unit_mp.sv
// Bench for register_unit_mp: default build (32x32, 2 ports) and a 16x64, 3-port instance.
// Expectations follow REGUNIT_BYPASS_EN when it is defined.
module tb_register_unit_mp;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    register_unit_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) ifa ();
    register_unit_mp_if #(.XLEN(64), .NREGS(16), .NRD(3)) ifb ();

    register_unit_mp #(.XLEN(32), .NREGS(32), .NRD(2)) dut_a (.CLK(clk), .RST_N(rst_a), .bus(ifa));
    register_unit_mp #(.XLEN(64), .NREGS(16), .NRD(3)) dut_b (.CLK(clk), .RST_N(rst_b), .bus(ifb));

    int n_vec = 0;
    int n_err = 0;

    // Reference model: register contents, busy set, and how far the clear has progressed.
    logic [63:0] m_mem [32];
    bit          m_busy[32];
    bit          m_run;
    int          m_init;

    logic [4:0]  cur_rs [3];
    logic [4:0]  cur_rd, cur_resrd;
    logic [63:0] cur_dw;
    bit          cur_wr, cur_res;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nregs_of(input int sel);
        return (sel == 0) ? 32 : 16;
    endfunction

    function automatic int nrd_of(input int sel);
        return (sel == 0) ? 2 : 3;
    endfunction

    function automatic logic [63:0] get_rus(input int sel, input int i);
        if (sel == 0) return {32'b0, ifa.Rus[i*32 +: 32]};
        return ifb.Rus[i*64 +: 64];
    endfunction

    function automatic logic get_busy(input int sel, input int i);
        return (sel == 0) ? ifa.RsBusy[i] : ifb.RsBusy[i];
    endfunction

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? ifa.Ready : ifb.Ready;
    endfunction

    function automatic logic [63:0] exp_rus(input int i);
        logic [4:0] r;
        r = cur_rs[i];
        if (!m_run || r == 5'd0) return 64'd0;
`ifdef REGUNIT_BYPASS_EN
        if (cur_wr && cur_rd == r) return cur_dw;
`endif
        return m_mem[r];
    endfunction

    function automatic logic exp_busy(input int i);
        logic [4:0] r;
        r = cur_rs[i];
        if (!m_run) return 1'b0;
`ifdef REGUNIT_BYPASS_EN
        if (cur_wr && cur_rd != 5'd0 && cur_rd == r && !(cur_res && cur_resrd == cur_rd)) return 1'b0;
`endif
        return m_busy[r];
    endfunction

    task automatic model_reset();
        m_run  = 1'b0;
        m_init = 0;
        for (int k = 0; k < 32; k++) begin
            m_mem[k]  = 64'd0;
            m_busy[k] = 1'b0;
        end
    endtask

    task automatic check(input int sel);
        chk("ready", {63'b0, get_ready(sel)}, {63'b0, m_run});
        for (int i = 0; i < nrd_of(sel); i++) begin
            chk("rus", get_rus(sel, i), exp_rus(i));
            chk("rsbusy", {63'b0, get_busy(sel, i)}, {63'b0, exp_busy(i)});
        end
    endtask

    task automatic apply(input int sel);
        if (sel == 0) begin
            ifa.rs     = {cur_rs[1], cur_rs[0]};
            ifa.rd     = cur_rd;
            ifa.DataWr = cur_dw[31:0];
            ifa.RuWr   = cur_wr;
            ifa.ResRd  = cur_resrd;
            ifa.ResEn  = cur_res;
        end else begin
            ifb.rs     = {cur_rs[2][3:0], cur_rs[1][3:0], cur_rs[0][3:0]};
            ifb.rd     = cur_rd[3:0];
            ifb.DataWr = cur_dw;
            ifb.RuWr   = cur_wr;
            ifb.ResRd  = cur_resrd[3:0];
            ifb.ResEn  = cur_res;
        end
    endtask

    task automatic drive(input int sel);
        @(negedge clk);
        apply(sel);
        #1;
        check(sel);
    endtask

    task automatic tick(input int sel);
        @(posedge clk);
        if (m_run) begin
            if (cur_wr && cur_rd != 5'd0) begin
                m_mem[cur_rd]  = cur_dw;
                m_busy[cur_rd] = 1'b0;
            end
            if (cur_res && cur_resrd != 5'd0) m_busy[cur_resrd] = 1'b1;
        end else begin
            m_init++;
            if (m_init == nregs_of(sel)) m_run = 1'b1;
        end
    endtask

    task automatic step(input int sel);
        drive(sel);
        tick(sel);
    endtask

    task automatic set_in(input logic [4:0] rs0, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [63:0] dw, input bit wr,
                          input logic [4:0] resrd, input bit res);
        cur_rs[0] = rs0; cur_rs[1] = rs1; cur_rs[2] = rs2;
        cur_rd = rd; cur_dw = dw; cur_wr = wr; cur_resrd = resrd; cur_res = res;
    endtask

    task automatic rand_in(input int sel);
        int n;
        n = nregs_of(sel) - 1;
        cur_rd = 5'($urandom_range(0, n));
        for (int i = 0; i < 3; i++)
            cur_rs[i] = ($urandom_range(0, 3) == 0) ? cur_rd : 5'($urandom_range(0, n));
        cur_dw    = (sel == 0) ? {32'b0, 32'($urandom)} : {32'($urandom), 32'($urandom)};
        cur_wr    = ($urandom_range(0, 1) == 1);
        cur_resrd = ($urandom_range(0, 3) == 0) ? cur_rd : 5'($urandom_range(0, n));
        cur_res   = ($urandom_range(0, 2) == 0);
    endtask

    // Assert reset asynchronously between edges, then release so the next edge starts INIT.
    task automatic do_reset(input int sel);
        @(negedge clk);
        if (sel == 0) rst_a = 1'b0; else rst_b = 1'b0;
        model_reset();
        #1;
        check(sel);
        chk("ready_drop", {63'b0, get_ready(sel)}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (sel == 0) rst_a = 1'b1; else rst_b = 1'b1;
        #1;
        check(sel);
        tick(sel);
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        apply(0);
        apply(1);
        model_reset();

        // ---------------- default instance ----------------
        do_reset(0);
        for (int c = 1; c < 32; c++) begin
            rand_in(0);
            step(0);
        end
        for (int r = 0; r < 32; r++) begin
            set_in(5'(r), 5'(31 - r), 0, 0, 0, 0, 0, 0);
            step(0);
        end

        set_in(0, 0, 0, 5, 64'hDEADBEEF, 1, 0, 0);
        step(0);
        set_in(5, 0, 0, 0, 0, 0, 0, 0);
        drive(0);
        chk("rd5", get_rus(0, 0), 64'hDEADBEEF);
        tick(0);
        set_in(0, 0, 0, 0, 64'h12345678, 1, 0, 0);
        step(0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0);
        chk("rd0", get_rus(0, 0), 64'd0);
        tick(0);

        set_in(0, 0, 0, 0, 0, 0, 7, 1);
        step(0);
        set_in(7, 0, 0, 0, 0, 0, 0, 0);
        drive(0);
        chk("busy7_set", {63'b0, get_busy(0, 0)}, 64'd1);
        tick(0);
        set_in(7, 0, 0, 7, 64'hA5A5A5A5, 1, 0, 0);
        step(0);
        set_in(7, 0, 0, 0, 0, 0, 0, 0);
        drive(0);
        chk("busy7_clr", {63'b0, get_busy(0, 0)}, 64'd0);
        chk("rd7", get_rus(0, 0), 64'hA5A5A5A5);
        tick(0);

        set_in(0, 0, 0, 9, 64'h99, 1, 9, 1);
        step(0);
        set_in(9, 9, 0, 0, 0, 0, 0, 0);
        drive(0);
        chk("busy9_wins", {63'b0, get_busy(0, 1)}, 64'd1);
        chk("rd9", get_rus(0, 0), 64'h99);
        tick(0);

        set_in(0, 3, 0, 3, 64'h0000CAFE, 1, 0, 0);
        drive(0);
`ifdef REGUNIT_BYPASS_EN
        chk("byp_same", get_rus(0, 1), 64'h0000CAFE);
`else
        chk("byp_same", get_rus(0, 1), 64'd0);
`endif
        tick(0);
        set_in(0, 3, 0, 0, 0, 0, 0, 0);
        drive(0);
        chk("byp_next", get_rus(0, 1), 64'h0000CAFE);
        tick(0);

        for (int c = 0; c < 400; c++) begin
            rand_in(0);
            step(0);
        end

        set_in(0, 0, 0, 4, 64'h11, 1, 6, 1);
        step(0);
        set_in(6, 4, 0, 0, 0, 0, 0, 0);
        drive(0);
        chk("busy6_pre", {63'b0, get_busy(0, 0)}, 64'd1);
        tick(0);
        do_reset(0);
        for (int c = 1; c < 32; c++) begin
            rand_in(0);
            cur_wr = 1'b1;
            step(0);
        end
        set_in(6, 4, 0, 0, 0, 0, 0, 0);
        drive(0);
        chk("ready_back", {63'b0, get_ready(0)}, 64'd1);
        chk("busy6_rst", {63'b0, get_busy(0, 0)}, 64'd0);
        chk("rd4_rst", get_rus(0, 1), 64'd0);
        tick(0);

        // ---------------- 16 x 64, three read ports ----------------
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset(1);
        for (int c = 1; c < 16; c++) begin
            rand_in(1);
            step(1);
        end
        set_in(0, 0, 0, 15, 64'hFFFF_0000_FFFF_0000, 1, 0, 0);
        drive(1);
        chk("b_ready", {63'b0, get_ready(1)}, 64'd1);
        tick(1);
        set_in(15, 15, 15, 0, 0, 0, 0, 0);
        drive(1);
        for (int i = 0; i < 3; i++) chk("b_rd15", get_rus(1, i), 64'hFFFF_0000_FFFF_0000);
        tick(1);
        for (int c = 0; c < 300; c++) begin
            rand_in(1);
            step(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
